// File: rtl/step_clock.sv
// Beat-driven step sequencer clock: a phase accumulator turns BPM into step/loop ticks.
// Optional count-in (4 beats before step 0) is enabled by defining STEP_CLOCK_COUNTIN_EN.
module step_clock #(
    parameter int CLK_HZ = 50_000_000,
    parameter int STEPS  = 16
) (
    input  logic       CLOCK_50,
    input  logic       nReset,
    input  logic [9:0] BPM,
    input  logic [6:0] Loops,
    input  logic       Start,
    input  logic       Stop,
    output logic       play_en,
    output logic       step_tick,
    output logic [3:0] step_idx,
    output logic [6:0] loop_idx,
    output logic       count_tick,
    output logic       done
);

    // One beat per minute-at-BPM: the accumulator gains BPM per clock and wraps at CLK_HZ*60.
    localparam logic [32:0] THR       = 33'(CLK_HZ) * 33'd60;
    localparam logic [3:0]  LAST_STEP = 4'(STEPS - 1);

`ifdef STEP_CLOCK_COUNTIN_EN
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        COUNT_IN = 4'b0010,
        RUN      = 4'b0100,
        DONE     = 4'b1000
    } state_e;
    logic [1:0]  cin_cnt;
`else
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_e;
    assign count_tick = 1'b0;
`endif

    state_e      state;
    logic        start_q;
    logic        start_armed;
    logic [31:0] acc;
    logic [9:0]  bpm_lat;
    logic [6:0]  loops_lat;
    logic [32:0] acc_sum;
    logic        beat;
    logic [31:0] acc_next;
    logic        start_ok;
    logic [6:0]  loop_next;

    // Start must be seen low once after reset, so a level held through reset cannot retrigger.
    assign start_ok  = start_armed && !start_q && Start && (BPM != '0) && (Loops != '0);
    assign acc_sum   = {1'b0, acc} + {23'd0, bpm_lat};
    assign beat      = (acc_sum >= THR);
    assign acc_next  = beat ? 32'(acc_sum - THR) : acc_sum[31:0];
    assign loop_next = loop_idx + 7'd1;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking assignments would make results order-dependent.
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            acc         <= '0;
            bpm_lat     <= '0;
            loops_lat   <= '0;
            play_en     <= 1'b0;
            step_tick   <= 1'b0;
            step_idx    <= '0;
            loop_idx    <= '0;
            done        <= 1'b0;
`ifdef STEP_CLOCK_COUNTIN_EN
            count_tick  <= 1'b0;
            cin_cnt     <= '0;
`endif
        end else begin
            start_q   <= Start;
            if (!Start) start_armed <= 1'b1;
            step_tick <= 1'b0;
            done      <= 1'b0;
`ifdef STEP_CLOCK_COUNTIN_EN
            count_tick <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        bpm_lat   <= BPM;
                        loops_lat <= Loops;
                        acc       <= '0;
                        step_idx  <= '0;
                        loop_idx  <= '0;
                        play_en   <= 1'b1;
`ifdef STEP_CLOCK_COUNTIN_EN
                        state      <= COUNT_IN;
                        count_tick <= 1'b1;
                        cin_cnt    <= '0;
`else
                        state     <= RUN;
                        step_tick <= 1'b1;
`endif
                    end
                end
`ifdef STEP_CLOCK_COUNTIN_EN
                COUNT_IN: begin
                    acc <= acc_next;
                    if (Stop) begin
                        state   <= DONE;
                        play_en <= 1'b0;
                        done    <= 1'b1;
                    end else if (beat) begin
                        // Fourth beat after entry starts step 0; the phase carries over.
                        if (cin_cnt == 2'd3) begin
                            state     <= RUN;
                            step_tick <= 1'b1;
                        end else begin
                            cin_cnt    <= cin_cnt + 2'd1;
                            count_tick <= 1'b1;
                        end
                    end
                end
`endif
                RUN: begin
                    acc <= acc_next;
                    if (Stop) begin
                        state   <= DONE;
                        play_en <= 1'b0;
                        done    <= 1'b1;
                    end else if (beat) begin
                        if (step_idx != LAST_STEP) begin
                            step_idx  <= step_idx + 4'd1;
                            step_tick <= 1'b1;
                        end else begin
                            step_idx <= '0;
                            loop_idx <= loop_next;
                            if (loop_next == loops_lat) begin
                                state   <= DONE;
                                play_en <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                step_tick <= 1'b1;
                            end
                        end
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/step_clock.md
STEP_CLOCK -- requirements
Module: step_clock

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the CLOCK_50 frequency in Hz.
REQ-002 SHALL have parameter STEPS, default 16, meaning steps per loop (range 2..16).
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port BPM, input, 10 bits: tempo from input_interface, one step per beat.
REQ-006 SHALL have port Loops, input, 7 bits: loop count from input_interface.
REQ-007 SHALL have port Start, input, 1 bit: level, high while input_interface is in play mode.
REQ-008 SHALL have port Stop, input, 1 bit: synchronous abort pulse.
REQ-009 SHALL have port play_en, output, 1 bit: playback active; wired to input_interface play_en.
REQ-010 SHALL have port step_tick, output, 1 bit: one-cycle pulse at the start of each step.
REQ-011 SHALL have port step_idx, output, 4 bits: index of the current step.
REQ-012 SHALL have port loop_idx, output, 7 bits: number of loops completed in this run.
REQ-013 SHALL have port count_tick, output, 1 bit: one-cycle count-in beat pulse.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a run finishes or aborts.

Function
REQ-015 SHALL implement the FSM states IDLE, COUNT_IN, RUN and DONE, all encoded one-hot.
REQ-016 SHALL register Start and detect its rising edge as the registered value 0 with the current value 1.
REQ-017 SHALL, in IDLE on a Start rising edge with BPM!=0 and Loops!=0, latch BPM and Loops, clear the accumulator, and go to RUN (or COUNT_IN per REQ-029).
REQ-018 SHALL remain in IDLE when BPM==0 or Loops==0 at the Start edge, with play_en held 0.
REQ-019 SHALL advance a 32-bit unsigned phase accumulator each cycle in COUNT_IN and RUN.
REQ-020 SHALL compute the accumulator update against THR=CLK_HZ*60 as follows:
  - if acc+bpm_lat >= THR, set acc <= acc+bpm_lat-THR and raise an internal beat for that cycle;
  - otherwise, set acc <= acc+bpm_lat.
REQ-021 SHALL, on the cycle RUN is entered, assert step_tick with step_idx=0, so the first-step latency is 1 cycle after the Start edge is seen.
REQ-022 SHALL, on each beat in RUN, perform the following:
  - if step_idx<STEPS-1, increment step_idx and pulse step_tick;
  - otherwise, increment loop_idx and set step_idx to 0;
  - if the new loop_idx equals the latched Loops, go to DONE with no step_tick;
  - otherwise, pulse step_tick.
REQ-023 SHALL assert play_en in COUNT_IN and RUN, registered, and deassert it in DONE and IDLE.
REQ-024 SHALL assert done for exactly the one DONE cycle, then go to IDLE.
REQ-025 SHALL, when Stop=1 in COUNT_IN or RUN, go to DONE next cycle, with Stop overriding a simultaneous beat (no step_tick that cycle).
REQ-026 SHALL ignore changes to BPM and Loops after the start latch until the next run.
REQ-027 SHALL leave step_idx and loop_idx holding their last values in IDLE and clear them at the next accepted start.

Reset
REQ-028 SHALL, on nReset=0 at any time including mid-run, immediately set state=IDLE, acc=0, play_en=0, step_tick=0, count_tick=0, done=0, step_idx=0, loop_idx=0 and the Start history to 0.

Configuration
REQ-029 SHALL, with the macro STEP_CLOCK_COUNTIN_EN defined, provide a count-in:
  - an accepted start enters COUNT_IN and pulses count_tick immediately, then on each of the next 3 beats (4 count_ticks total);
  - the 4th beat after entry enters RUN at step 0 with the accumulator not cleared.
REQ-030 SHALL, without STEP_CLOCK_COUNTIN_EN, omit the COUNT_IN state, tie count_tick to 0, and keep the port present.

Verification (CLK_HZ=1000, THR=60000, STEPS=16)
REQ-031 SHALL cover: BPM=600, Loops=1, Start rising -> step_tick 1 cycle later with step_idx=0, then every 100 cycles through step 15; done 1600 cycles after the first tick; play_en low from that cycle.
REQ-032 SHALL cover: BPM=7, Loops=2 -> step_tick intervals of 8571 or 8572 cycles, with a long-run average of 60000/7; loop_idx=1 after step 15; 32 ticks total.
REQ-033 SHALL cover: BPM=0 or Loops=0 with Start pulsed -> play_en, step_tick and done stay 0.
REQ-034 SHALL cover: Stop asserted on the same cycle as a beat at step 5 -> no step_tick, done next cycle, step_idx holds 5.
REQ-035 SHALL cover: nReset asserted mid-RUN at step 9 -> all outputs zero asynchronously; Start held high after release causes no restart until it falls and rises.
REQ-036 SHALL cover, with STEP_CLOCK_COUNTIN_EN defined: BPM=600 -> count_tick at cycles 1, 101, 201 and 301, then step_tick at cycle 401 with step_idx=0.
